// File: rtl/dm_spi_frame_scheduler.sv
// rtl/dm_spi_frame_scheduler.sv - frame sequencer driving six SPI DAC ports across four chip selects
module dm_spi_frame_scheduler #(
  parameter int NPORTS         = 6,
  parameter int NCS            = 4,
  parameter int WORD_W         = 24,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cfg_we,
  input  logic [4:0]               i_cfg_addr,
  input  logic [WORD_W-1:0]        i_cfg_wdata,
  input  logic [NPORTS*NCS-1:0]    i_slot_mask,
  input  logic                     i_sw_trigger,
  input  logic                     i_pps,
  input  logic                     i_pps_en,
  input  logic [NPORTS-1:0]        i_spi_done,
  output logic [NPORTS-1:0]        o_spi_start,
  output logic [NPORTS*WORD_W-1:0] o_spi_data,
  output logic [1:0]               o_spi_cs_sel,
  output logic                     o_busy,
  output logic                     o_frame_done,
  output logic                     o_overrun,
  output logic                     o_timeout_err,
  output logic [15:0]              o_frame_count
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE} state_t;

  state_t                     r_state, w_state_nxt;
  logic [WORD_W-1:0]          r_shadow [NCS][NPORTS];
  logic [1:0]                 r_cs_idx;
  logic [NPORTS-1:0]          r_pending;
  logic [NPORTS-1:0]          r_spi_start;
  logic [NPORTS*WORD_W-1:0]   r_spi_data;
  logic [1:0]                 r_spi_cs_sel;
  logic                       r_busy;
  logic                       r_overrun;
  logic                       r_timeout_err;
  logic [15:0]                r_frame_count;
  logic [TW-1:0]              r_to_cnt;
  logic [GW-1:0]              r_gap_cnt;
  logic                       w_trig;
  logic                       w_to_hit;
  logic                       w_gap_end;
  logic                       w_last_cs;
  logic [NPORTS-1:0]          w_mask;

  assign w_trig    = i_sw_trigger | (i_pps & i_pps_en);
  assign w_mask    = i_slot_mask[r_cs_idx*NPORTS +: NPORTS];
  assign w_to_hit  = (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_gap_end = (r_gap_cnt == GW'(GAP_CYCLES - 1));
  assign w_last_cs = (r_cs_idx == 2'(NCS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_trig) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = (w_mask == '0) ? S_GAP : S_WAIT;
      S_WAIT: begin
        if (r_pending == '0) w_state_nxt = S_GAP;
        else if (w_to_hit)   w_state_nxt = S_IDLE;
      end
      S_GAP:   if (w_gap_end) w_state_nxt = w_last_cs ? S_DONE : S_ISSUE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < NCS; c++)
        for (int p = 0; p < NPORTS; p++)
          r_shadow[c][p] <= '0;
      r_cs_idx      <= '0;
      r_pending     <= '0;
      r_spi_start   <= '0;
      r_spi_data    <= '0;
      r_spi_cs_sel  <= '0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_frame_count <= '0;
      r_to_cnt      <= '0;
      r_gap_cnt     <= '0;
    end else begin
      r_spi_start <= '0;
      r_overrun   <= w_trig && (r_state != S_IDLE);
      if (i_cfg_we && (i_cfg_addr[2:0] < 3'(NPORTS)))
        r_shadow[i_cfg_addr[4:3]][i_cfg_addr[2:0]] <= i_cfg_wdata;
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_cs_idx      <= '0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        S_ISSUE: begin
          for (int p = 0; p < NPORTS; p++)
            r_spi_data[p*WORD_W +: WORD_W] <= r_shadow[r_cs_idx][p];
          r_spi_start  <= w_mask;
          r_pending    <= w_mask;
          r_spi_cs_sel <= r_cs_idx;
          r_to_cnt     <= '0;
          r_gap_cnt    <= '0;
        end
        S_WAIT: begin
          // A done coincident with this group's start pulse belongs to nothing we issued.
          r_pending <= r_pending & ~(i_spi_done & ~r_spi_start);
          if (r_pending != '0) begin
            r_to_cnt <= r_to_cnt + 1'b1;
            if (w_to_hit) begin
              r_timeout_err <= 1'b1;
              r_busy        <= 1'b0;
              r_pending     <= '0;
            end
          end
        end
        S_GAP: begin
          r_gap_cnt <= r_gap_cnt + 1'b1;
          if (w_gap_end && !w_last_cs) r_cs_idx <= r_cs_idx + 1'b1;
        end
        S_DONE: begin
          r_frame_count <= r_frame_count + 1'b1;
          r_busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_spi_start   = r_spi_start;
  assign o_spi_data    = r_spi_data;
  assign o_spi_cs_sel  = r_spi_cs_sel;
  assign o_busy        = r_busy;
  assign o_frame_done  = (r_state == S_DONE);
  assign o_overrun     = r_overrun;
  assign o_timeout_err = r_timeout_err;
  assign o_frame_count = r_frame_count;

endmodule
